// File: rtl/permutation_sequencer_pkg.sv
// Shared types and defaults for the line-permutation sequencer.
package permutation_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_PERMUTE = 3'd2,
        ST_WRITE   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam int LINE_W        = 25;
    localparam int DEF_NUM_LINES = 64;
    localparam int DEF_ADDR_W    = 6;

endpackage

// File: rtl/permutation_sequencer_line_counter.sv
// Line address up-counter with terminal-count flag; saturates at NUM_LINES-1.
module line_counter #(
    parameter int ADDR_W    = 6,
    parameter int NUM_LINES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] value,
    output logic              tc
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_LINES - 1);

    assign tc = (value == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc && !tc) begin
            value <= value + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/permutation_sequencer.sv
// Walks lines 0..NUM_LINES-1: fetch, ROUNDS permute passes, write back, with
// reader/writer handshakes and abort.
module permutation_sequencer
    import permutation_sequencer_pkg::*;
#(
    parameter int NUM_LINES = DEF_NUM_LINES,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int ROUNDS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              rd_ack,
    input  logic              wr_ack,
    output logic [ADDR_W-1:0] line_addr,
    output logic              rd_req,
    output logic              reg_clr,
    output logic              reg_ld,
    output logic              sel_perm,
    output logic              perm_en,
    output logic              wr_req,
    output logic              busy,
    output logic              done
);

    localparam int RND_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [RND_W-1:0] LAST_ROUND = RND_W'(ROUNDS - 1);

    state_t           state, state_nx;
    logic [RND_W-1:0] round;
    logic             cnt_clr, cnt_inc, last_line;
    logic             rnd_clr, rnd_inc;

    line_counter #(
        .ADDR_W    (ADDR_W),
        .NUM_LINES (NUM_LINES)
    ) u_line_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .value (line_addr),
        .tc    (last_line)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            round <= '0;
        end else if (rnd_clr) begin
            round <= '0;
        end else if (rnd_inc) begin
            round <= (round == LAST_ROUND) ? '0 : round + RND_W'(1);
        end
    end

    always_comb begin
        state_nx = state;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        rnd_clr  = 1'b0;
        rnd_inc  = 1'b0;
        rd_req   = 1'b0;
        reg_clr  = 1'b0;
        reg_ld   = 1'b0;
        sel_perm = 1'b0;
        perm_en  = 1'b0;
        wr_req   = 1'b0;
        done     = 1'b0;
        busy     = (state != ST_IDLE);

        // Moore decode; reg_ld in READ additionally qualifies on the ack.
        unique case (state)
            ST_IDLE: reg_clr = 1'b1;
            ST_READ: begin
                rd_req = 1'b1;
                reg_ld = rd_ack;
            end
            ST_PERMUTE: begin
                perm_en  = 1'b1;
                sel_perm = 1'b1;
                reg_ld   = 1'b1;
            end
            ST_WRITE: wr_req = 1'b1;
            ST_DONE:  done   = 1'b1;
            default: ;
        endcase

        // Abort outranks any handshake landing in the same cycle.
        if (state != ST_IDLE && abort) begin
            state_nx = ST_IDLE;
            cnt_clr  = 1'b1;
            rnd_clr  = 1'b1;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    cnt_clr = 1'b1;
                    if (start) begin
                        state_nx = ST_READ;
                        rnd_clr  = 1'b1;
                    end
                end
                ST_READ: begin
                    if (rd_ack) begin
                        state_nx = ST_PERMUTE;
                        rnd_clr  = 1'b1;
                    end
                end
                ST_PERMUTE: begin
                    rnd_inc = 1'b1;
                    if (round == LAST_ROUND) begin
                        state_nx = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (wr_ack) begin
                        if (last_line) begin
                            state_nx = ST_DONE;
                        end else begin
                            cnt_inc  = 1'b1;
                            state_nx = ST_READ;
                        end
                    end
                end
                ST_DONE: begin
                    state_nx = ST_IDLE;
                    cnt_clr  = 1'b1;
                end
                default: begin
                    state_nx = ST_IDLE;
                    cnt_clr  = 1'b1;
                    rnd_clr  = 1'b1;
                end
            endcase
        end
    end

endmodule
